// File: rtl/avalon_timer_pkg.sv
// rtl/avalon_timer_pkg.sv - register map, bit indices and helpers for the multi-channel timer
package avalon_timer_pkg;

  // Per-channel register offsets (address[2:0])
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;

  // CONTROL bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // STATUS bit positions
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // Channel-select width, never narrower than one bit
  function automatic int ch_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_multi_timer_if.sv
// rtl/avalon_multi_timer_if.sv - slave-port bundle for the multi-channel timer
interface avalon_multi_timer_if #(
  parameter int NUM_CH = 2,
  parameter int CH_AW  = 1
);
  logic [3+CH_AW-1:0] address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [15:0]        readdata;
  logic               irq;
  logic [NUM_CH-1:0]  irq_vec;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, irq_vec
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, irq_vec
  );
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: registers, prescaler, down-counter, timeout
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [2:0]  offset_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        irq_o,
  output logic        timeout_o
);
  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
  logic [15:0]      presc_q, presc_d, pcnt_q, pcnt_d;
  logic             cont_q, cont_d, ito_q, ito_d, run_q, run_d, to_q, to_d;
  logic             force_q, force_d, zero_q;
  logic             zero, tick;
  logic [31:0]      period_ext, snap_ext;
  logic [15:0]      status;

  assign zero       = (cnt_q == '0);
  assign tick       = run_q && (pcnt_q == 16'd0);
  assign timeout_o  = zero && !zero_q;
  assign irq_o      = to_q && ito_q;
  // Zero-extended views so the high halves read 0 for narrow counters
  assign period_ext = 32'(period_q);
  assign snap_ext   = 32'(snap_q);

  // Next state: counting first, then the period-write reload, then register writes override
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    cont_d   = cont_q;
    ito_d    = ito_q;
    run_d    = run_q;
    to_d     = to_q;
    force_d  = 1'b0;

    if (run_q) pcnt_d = (pcnt_q == 16'd0) ? presc_q : pcnt_q - 16'd1;
    if (tick) begin
      cnt_d = zero ? period_q : cnt_q - CNT_W'(1);
      if (zero && !cont_q) run_d = 1'b0;
    end
    if (force_q) begin
      cnt_d  = period_q;
      pcnt_d = presc_q;
      run_d  = 1'b0;
    end
    if (timeout_o) to_d = 1'b1;

    if (wr_en_i) begin
      case (offset_i)
        REG_STATUS: to_d = 1'b0;
        REG_CONTROL: begin
          cont_d = wdata_i[CTRL_CONT];
          ito_d  = wdata_i[CTRL_ITO];
          if (wdata_i[CTRL_START]) begin
            run_d  = 1'b1;
            pcnt_d = presc_q;
          end else if (wdata_i[CTRL_STOP]) begin
            run_d = 1'b0;
          end
        end
        REG_PERIOD_L: begin
          period_d = CNT_W'({period_ext[31:16], wdata_i});
          force_d  = 1'b1;
        end
        REG_PERIOD_H: begin
          period_d = CNT_W'({wdata_i, period_ext[15:0]});
          force_d  = 1'b1;
        end
        REG_SNAP_L, REG_SNAP_H: snap_d = cnt_q;
        REG_PRESCALE: presc_d = wdata_i;
        default: ;
      endcase
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= CNT_W'(RESET_PERIOD);
      cnt_q    <= CNT_W'(RESET_PERIOD);
      snap_q   <= '0;
      presc_q  <= 16'd0;
      pcnt_q   <= 16'd0;
      cont_q   <= 1'b0;
      ito_q    <= 1'b0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      force_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      cont_q   <= cont_d;
      ito_q    <= ito_d;
      run_q    <= run_d;
      to_q     <= to_d;
      force_q  <= force_d;
      zero_q   <= zero;
    end
  end

  // Read value of the addressed register in this channel
  always_comb begin
    status         = 16'h0;
    status[ST_TO]  = to_q;
    status[ST_RUN] = run_q;
    case (offset_i)
      REG_STATUS:   rdata_o = status;
      REG_CONTROL:  rdata_o = {14'b0, cont_q, ito_q};
      REG_PERIOD_L: rdata_o = period_ext[15:0];
      REG_PERIOD_H: rdata_o = period_ext[31:16];
      REG_SNAP_L:   rdata_o = snap_ext[15:0];
      REG_SNAP_H:   rdata_o = snap_ext[31:16];
      REG_PRESCALE: rdata_o = presc_q;
      default:      rdata_o = 16'h0;
    endcase
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// rtl/avalon_multi_timer.sv - NUM_CH interval timers behind one slave port; TIMER_PULSE_OUT_EN adds timeout_pulse
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999,
  parameter int CH_AW        = ch_aw(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_multi_timer_if.slave bus
`ifdef TIMER_PULSE_OUT_EN
  ,
  output logic [NUM_CH-1:0]   timeout_pulse
`endif
);
  logic [CH_AW-1:0]  ch_idx;
  logic [2:0]        offset;
  logic              wr_req;
  logic [15:0]       ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;
  logic [NUM_CH-1:0] ch_timeout;
  logic [15:0]       readdata_d, readdata_q;

  assign ch_idx = bus.address[3+CH_AW-1:3];
  assign offset = bus.address[2:0];
  assign wr_req = bus.chipselect && !bus.write_n;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (wr_req && (int'(ch_idx) == gi)),
      .offset_i  (offset),
      .wdata_i   (bus.writedata),
      .rdata_o   (ch_rdata[gi]),
      .irq_o     (ch_irq[gi]),
      .timeout_o (ch_timeout[gi])
    );
  end

  // Select the addressed channel; unpopulated channel indices read 0
  always_comb begin
    readdata_d = 16'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_idx) == i) readdata_d = ch_rdata[i];
    end
  end

  // Read data is registered every cycle, independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= 16'h0;
    else          readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq_vec  = ch_irq;
  assign bus.irq      = |ch_irq;

`ifdef TIMER_PULSE_OUT_EN
  logic [NUM_CH-1:0] pulse_q;

  // One-clock trigger per timeout event, independent of TO and ITO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pulse_q <= '0;
    else          pulse_q <= ch_timeout;
  end

  assign timeout_pulse = pulse_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^ch_timeout;
`endif

endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb/tb_avalon_multi_timer.sv - self-checking bench for avalon_multi_timer
module tb_avalon_multi_timer;
  import avalon_timer_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CH_AW  = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  avalon_multi_timer_if #(.NUM_CH(NUM_CH), .CH_AW(CH_AW)) bus_if ();

`ifdef TIMER_PULSE_OUT_EN
  logic [NUM_CH-1:0] timeout_pulse;
`endif

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (32),
    .RESET_PERIOD (9999)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
`ifdef TIMER_PULSE_OUT_EN
    , .timeout_pulse (timeout_pulse)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  typedef struct {
    bit          wr;
    int          ch;
    logic [2:0]  off;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  rd_exp_t sb_q[$];
  rd_exp_t sb_e;
  vec_t    vecs[22];
  logic    rd_pend   = 1'b0;
  logic    rd_issued = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3+CH_AW-1:0] mk_addr(input int ch, input logic [2:0] off);
    logic [CH_AW-1:0] c;
    c = CH_AW'(ch);
    return {c, off};
  endfunction

  task automatic bus_write(input int ch, input logic [2:0] off, input logic [15:0] wd);
    bus_if.address    = mk_addr(ch, off);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = wd;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input string nm, input int ch, input logic [2:0] off, input logic [15:0] exp);
    bus_if.address    = mk_addr(ch, off);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    sb_q.push_back('{name: nm, exp: exp});
    rd_pend = 1'b1;
    @(negedge clk);
    rd_pend           = 1'b0;
    bus_if.chipselect = 1'b0;
  endtask

  always @(posedge clk) rd_issued <= rd_pend;

  // Read-data monitor: one clock after a read is issued, compare against the scoreboard
  always @(negedge clk) begin
    if (rd_issued) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: readdata 0x%0h with no expectation queued", bus_if.readdata);
      end else begin
        sb_e = sb_q.pop_front();
        chk(sb_e.name, 32'(bus_if.readdata), 32'(sb_e.exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 0, REG_PERIOD_L, 16'h0000, 16'h270F};
    vecs[1]  = '{1'b0, 0, REG_PERIOD_H, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 0, REG_STATUS,   16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 0, REG_CONTROL,  16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 0, REG_PRESCALE, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 0, REG_SNAP_L,   16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1, REG_PERIOD_L, 16'h0000, 16'h270F};
    vecs[7]  = '{1'b0, 2, REG_PERIOD_L, 16'h0000, 16'h270F};
    vecs[8]  = '{1'b0, 0, 3'd7,         16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 3, REG_PERIOD_L, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 2, REG_PRESCALE, 16'hABCD, 16'hABCD};
    vecs[11] = '{1'b1, 2, REG_CONTROL,  16'h0002, 16'h0002};
    vecs[12] = '{1'b1, 2, REG_CONTROL,  16'h0001, 16'h0001};
    vecs[13] = '{1'b1, 2, REG_CONTROL,  16'h0000, 16'h0000};
    vecs[14] = '{1'b1, 2, REG_PERIOD_H, 16'h1234, 16'h1234};
    vecs[15] = '{1'b1, 2, REG_PERIOD_L, 16'h270F, 16'h270F};
    vecs[16] = '{1'b1, 2, 3'd7,         16'h5555, 16'h0000};
    vecs[17] = '{1'b1, 3, REG_PRESCALE, 16'h0001, 16'h0000};
    vecs[18] = '{1'b1, 2, REG_STATUS,   16'hFFFF, 16'h0000};
    vecs[19] = '{1'b1, 2, REG_SNAP_L,   16'h0000, 16'h270F};
    vecs[20] = '{1'b0, 2, REG_SNAP_H,   16'h0000, 16'h1234};
    vecs[21] = '{1'b0, 1, REG_PRESCALE, 16'h0000, 16'h0000};

    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 16'h0;
    reset_n           = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", 32'(bus_if.readdata), 32'h0);
    chk("rst_irq", 32'(bus_if.irq), 32'h0);
    chk("rst_irq_vec", 32'(bus_if.irq_vec), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map vectors
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].ch, vecs[i].off, vecs[i].wd);
      bus_read($sformatf("vec%0d", i), vecs[i].ch, vecs[i].off, vecs[i].exp);
    end

    // ch1 continuous, period 4, no prescale
    bus_write(1, REG_PERIOD_L, 16'd4);
    bus_write(1, REG_PERIOD_H, 16'd0);
    bus_write(1, REG_PRESCALE, 16'd0);
    bus_write(1, REG_CONTROL, 16'h0007);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("a_quiet%0d", k), 32'(bus_if.irq_vec[1]), 32'h0);
      @(negedge clk);
    end
    chk("a_irq_first", 32'(bus_if.irq_vec[1]), 32'h1);
    chk("a_irq_or", 32'(bus_if.irq), 32'h1);
    bus_write(1, REG_STATUS, 16'h0);
    chk("a_irq_cleared", 32'(bus_if.irq_vec[1]), 32'h0);
    chk("a_irq_or_cleared", 32'(bus_if.irq), 32'h0);
    repeat (3) @(negedge clk);
    chk("a_before_second", 32'(bus_if.irq_vec[1]), 32'h0);
    @(negedge clk);
    chk("a_second", 32'(bus_if.irq_vec[1]), 32'h1);
    repeat (4) @(negedge clk);
    bus_write(1, REG_STATUS, 16'h0);
    chk("a_status_wins", 32'(bus_if.irq_vec[1]), 32'h0);
    repeat (5) @(negedge clk);
    chk("a_fourth", 32'(bus_if.irq_vec[1]), 32'h1);
    bus_write(1, REG_CONTROL, 16'h0008);
    bus_write(1, REG_STATUS, 16'h0);
    bus_read("a_stopped", 1, REG_STATUS, 16'h0000);
    bus_write(1, REG_CONTROL, 16'h000C);
    bus_read("a_start_wins", 1, REG_STATUS, 16'h0002);
    bus_write(1, REG_CONTROL, 16'h0008);

    // ch0 one-shot, period 2, prescale 3
    bus_write(0, REG_PERIOD_L, 16'd2);
    bus_write(0, REG_PRESCALE, 16'd3);
    bus_write(0, REG_CONTROL, 16'h0005);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b_quiet%0d", k), 32'(bus_if.irq_vec[0]), 32'h0);
      @(negedge clk);
    end
    chk("b_irq", 32'(bus_if.irq_vec[0]), 32'h1);
    bus_read("b_status_run", 0, REG_STATUS, 16'h0003);
    repeat (3) @(negedge clk);
    bus_read("b_status_done", 0, REG_STATUS, 16'h0001);
    bus_write(0, REG_SNAP_L, 16'h0);
    bus_read("b_reloaded_l", 0, REG_SNAP_L, 16'h0002);
    bus_read("b_reloaded_h", 0, REG_SNAP_H, 16'h0000);

    // ch2 snapshot while running, then period write reload
    bus_write(2, REG_PRESCALE, 16'd0);
    bus_write(2, REG_CONTROL, 16'h0006);
    repeat (3) @(negedge clk);
    bus_write(2, REG_SNAP_L, 16'h0);
    bus_read("c_snap_l", 2, REG_SNAP_L, 16'h270C);
    bus_read("c_snap_h", 2, REG_SNAP_H, 16'h1234);
    bus_write(2, REG_PERIOD_L, 16'h0010);
    bus_read("c_run_still", 2, REG_STATUS, 16'h0002);
    bus_read("c_run_cleared", 2, REG_STATUS, 16'h0000);
    bus_write(2, REG_SNAP_L, 16'h0);
    bus_read("c_reload_l", 2, REG_SNAP_L, 16'h0010);
    bus_read("c_reload_h", 2, REG_SNAP_H, 16'h1234);

`ifdef TIMER_PULSE_OUT_EN
    // ch1 continuous without ITO: trigger pulse only
    bus_write(1, REG_PERIOD_L, 16'd4);
    bus_write(1, REG_CONTROL, 16'h0006);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("d_quiet%0d", k), 32'(timeout_pulse), 32'h0);
      @(negedge clk);
    end
    chk("d_pulse", 32'(timeout_pulse), 32'h2);
    chk("d_no_irq", 32'(bus_if.irq_vec[1]), 32'h0);
    @(negedge clk);
    chk("d_pulse_end", 32'(timeout_pulse), 32'h0);
    repeat (4) @(negedge clk);
    chk("d_pulse2", 32'(timeout_pulse), 32'h2);
    @(negedge clk);
    chk("d_pulse2_end", 32'(timeout_pulse), 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
